// File: rtl/mux_n_to_1_pipe_pkg.sv
// Shared constants and types for the registered N:1 word selector.
package mux_n_to_1_pipe_pkg;

    // Default datapath word width and the largest input count the selector supports.
    localparam int MUXP_WORD_WIDTH = 32;
    localparam int MUXP_MAX_INPUTS = 16;

    // Occupancy of the output stage: nothing held, main register only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } muxp_state_e;

endpackage

// File: rtl/mux_n_to_1_pipe_comb.sv
// Pure combinational NUM_INPUTS:1 word selector.
// An index with no matching input yields an all-zero word and raises range_err.
module mux_n_to_1_comb
    import mux_n_to_1_pipe_pkg::*;
#(
    parameter  int WORD_WIDTH = MUXP_WORD_WIDTH,
    parameter  int NUM_INPUTS = 4,
    localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [SEL_WIDTH-1:0]             select,
    input  logic [NUM_INPUTS*WORD_WIDTH-1:0] inp_flat,
    output logic [WORD_WIDTH-1:0]            word,
    output logic                             range_err
);

    // Scan every legal index; anything not matched stays zero and flags the error.
    always_comb begin
        word      = '0;
        range_err = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (select == SEL_WIDTH'(i)) begin
                word      = inp_flat[i*WORD_WIDTH +: WORD_WIDTH];
                range_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// Registered N:1 word selector with valid/ready flow control.
// A two-entry skid (main + skid register) keeps full throughput under
// backpressure while in_ready stays a pure flop output.
//
//  state    | meaning
//  ---------+-------------------------------------------
//  ST_EMPTY | nothing held, out_valid = 0
//  ST_ONE   | main register valid, skid empty
//  ST_TWO   | main and skid valid, in_ready = 0
module mux_n_to_1_pipe
    import mux_n_to_1_pipe_pkg::*;
#(
    parameter  int WORD_WIDTH = MUXP_WORD_WIDTH,
    parameter  int NUM_INPUTS = 4,
    localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SEL_WIDTH-1:0]             select,
    input  logic [NUM_INPUTS*WORD_WIDTH-1:0] inp_flat,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH-1:0]            out,
    output logic                             sel_err
);

    if (NUM_INPUTS < 2 || NUM_INPUTS > MUXP_MAX_INPUTS) begin : g_bad_num_inputs
        $error("mux_n_to_1_pipe: NUM_INPUTS must be in 2..%0d", MUXP_MAX_INPUTS);
    end

    logic [WORD_WIDTH-1:0] sel_word;
    logic                  sel_range_err;

    mux_n_to_1_comb #(
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_INPUTS (NUM_INPUTS)
    ) u_sel (
        .select    (select),
        .inp_flat  (inp_flat),
        .word      (sel_word),
        .range_err (sel_range_err)
    );

    muxp_state_e           state_q,     state_d;
    logic [WORD_WIDTH-1:0] data_q,      data_d;
    logic [WORD_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  sel_err_q,   sel_err_d;

    logic accept;
    logic xfer;

    assign accept = in_valid && in_ready_q && !flush;
    assign xfer   = out_valid_q && out_ready;

    // Next occupancy and data movement; flush overrides everything and keeps out data.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        skid_data_d = skid_data_q;
        sel_err_d   = sel_err_q;

        if (flush) begin
            state_d   = ST_EMPTY;
            sel_err_d = 1'b0;
        end else begin
            if (accept && sel_range_err) begin
                sel_err_d = 1'b1;
            end
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        data_d  = sel_word;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        data_d = sel_word;
                    end else if (accept) begin
                        skid_data_d = sel_word;
                        state_d     = ST_TWO;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (xfer) begin
                        data_d  = skid_data_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Handshake outputs are registered copies of the next occupancy.
        out_valid_d  = (state_d != ST_EMPTY);
        skid_valid_d = (state_d == ST_TWO);
        in_ready_d   = (state_d != ST_TWO);
    end

    // State and output registers; reset drops any buffered words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = data_q;
    assign sel_err   = sel_err_q;

    // Skid occupancy is tracked redundantly with the state; the two must never disagree.
    wire unused_ok = skid_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Bench for mux_n_to_1_pipe: a 4-input and a 3-input instance share stimulus,
// each checked every cycle against a queue model, plus literal spot checks.
module tb_mux_n_to_1_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [1:0]  select;
    logic [31:0] words [4];
    logic [127:0] inp_flat;

    logic [1:0]        in_ready_w;
    logic [1:0]        out_valid_w;
    logic [1:0]        sel_err_w;
    logic [1:0][31:0]  out_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign inp_flat = {words[3], words[2], words[1], words[0]};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int N = (g == 0) ? 4 : 3;

        mux_n_to_1_pipe #(.WORD_WIDTH(32), .NUM_INPUTS(N)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .select    (select),
            .inp_flat  (inp_flat[N*32-1:0]),
            .flush     (flush),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out       (out_w[g]),
            .sel_err   (sel_err_w[g])
        );

        logic [31:0] q [$];
        bit          m_err;
        int          n_held;
        bit          acc;
        bit          xf;

        // Model: a FIFO of at most two words that the block is holding.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                m_err = 1'b0;
            end else begin
                n_held = q.size();
                acc    = in_valid && (n_held < 2) && !flush;
                xf     = (n_held > 0) && out_ready;
                if (flush) begin
                    q.delete();
                    m_err = 1'b0;
                end else begin
                    if (xf) void'(q.pop_front());
                    if (acc) begin
                        if (int'(select) < N) q.push_back(words[select]);
                        else begin
                            q.push_back(32'h0);
                            m_err = 1'b1;
                        end
                    end
                end
            end
        end

        // Compare every cycle, away from the active edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("rst_out_valid%0d", g), {31'b0, out_valid_w[g]}, 32'h0);
                chk($sformatf("rst_out%0d", g), out_w[g], 32'h0);
                chk($sformatf("rst_sel_err%0d", g), {31'b0, sel_err_w[g]}, 32'h0);
            end else begin
                chk($sformatf("out_valid%0d", g), {31'b0, out_valid_w[g]}, {31'b0, q.size() > 0});
                chk($sformatf("in_ready%0d", g), {31'b0, in_ready_w[g]}, {31'b0, q.size() < 2});
                chk($sformatf("sel_err%0d", g), {31'b0, sel_err_w[g]}, {31'b0, m_err});
                if (q.size() > 0) chk($sformatf("out%0d", g), out_w[g], q[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        select    = 2'd0;
        words[0]  = 32'h11111111;
        words[1]  = 32'h22222222;
        words[2]  = 32'h33333333;
        words[3]  = 32'h44444444;

        // Reset state.
        step();
        step();
        chk("reset_out_valid", {31'b0, out_valid_w[0]}, 32'h0);
        chk("reset_out", out_w[0], 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_reset_in_ready", {31'b0, in_ready_w[0]}, 32'h1);

        // Basic select of input 2.
        select   = 2'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("basic_out", out_w[0], 32'h33333333);
        chk("basic_out_valid", {31'b0, out_valid_w[0]}, 32'h1);
        step();
        chk("basic_drain", {31'b0, out_valid_w[0]}, 32'h0);

        // Streaming 0..3 at one word per cycle.
        for (int s = 0; s < 4; s++) begin
            select   = 2'(s);
            in_valid = 1'b1;
            step();
            chk("stream_out", out_w[0], words[s]);
            chk("stream_in_ready", {31'b0, in_ready_w[0]}, 32'h1);
        end
        in_valid = 1'b0;
        chk("stream_sel3_n3_err", {31'b0, sel_err_w[1]}, 32'h1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_clears_err", {31'b0, sel_err_w[1]}, 32'h0);

        // Backpressure: three words offered, two taken.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        select    = 2'd0;
        step();
        select = 2'd1;
        step();
        chk("bp_in_ready_low", {31'b0, in_ready_w[0]}, 32'h0);
        chk("bp_out_hold", out_w[0], 32'h11111111);
        select = 2'd2;
        step();
        chk("bp_out_still", out_w[0], 32'h11111111);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_second_word", out_w[0], 32'h22222222);
        chk("bp_in_ready_back", {31'b0, in_ready_w[0]}, 32'h1);
        step();
        chk("bp_empty", {31'b0, out_valid_w[0]}, 32'h0);

        // Out-of-range select on the 3-input instance.
        select   = 2'd3;
        in_valid = 1'b1;
        step();
        chk("oor_out_zero", out_w[1], 32'h0);
        chk("oor_sel_err", {31'b0, sel_err_w[1]}, 32'h1);
        select = 2'd1;
        step();
        in_valid = 1'b0;
        chk("oor_legal_out", out_w[1], 32'h22222222);
        chk("oor_err_sticky", {31'b0, sel_err_w[1]}, 32'h1);
        step();
        chk("oor_err_sticky2", {31'b0, sel_err_w[1]}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("oor_flush_clear", {31'b0, sel_err_w[1]}, 32'h0);

        // Out-of-range accept attempted together with flush: flush wins.
        select   = 2'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("oor_and_flush", {31'b0, sel_err_w[1]}, 32'h0);
        chk("oor_and_flush_valid", {31'b0, out_valid_w[1]}, 32'h0);

        // Flush with a full buffer and a word arriving the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        select    = 2'd0;
        step();
        select = 2'd1;
        step();
        select = 2'd2;
        flush  = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", {31'b0, out_valid_w[0]}, 32'h0);
        chk("flush_full_in_ready", {31'b0, in_ready_w[0]}, 32'h1);
        out_ready = 1'b1;
        step();
        chk("flush_nothing_after", {31'b0, out_valid_w[0]}, 32'h0);
        step();

        // Asynchronous reset while holding two words, with sel_err set.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        select    = 2'd3;
        step();
        select = 2'd1;
        step();
        in_valid = 1'b0;
        chk("pre_async_err", {31'b0, sel_err_w[1]}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'b0, out_valid_w[0]}, 32'h0);
        chk("async_out", out_w[0], 32'h0);
        chk("async_sel_err", {31'b0, sel_err_w[1]}, 32'h0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Mixed traffic, checked by the model every cycle.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            select    = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 19) == 0);
            words[i % 4] = $urandom;
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
